// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order {instruction, PC} queue between fetch and decode, emptied in one cycle on redirect.
// Optional same-cycle bypass through an empty buffer is enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [DATA_WIDTH-1:0]      fetch_instr,
    input  logic [ADDRESS_WIDTH-1:0]   fetch_pc,
    input  logic                       flush,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [DATA_WIDTH-1:0]      dec_instr,
    output logic [ADDRESS_WIDTH-1:0]   dec_pc,
    output logic [ADDRESS_WIDTH-1:0]   dec_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]         FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0]    NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);

    logic [DATA_WIDTH-1:0]    r_instr_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bypass;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

`ifdef FETCH_BUFFER_BYPASS_EN
    // Empty buffer with decode ready: hand the fetch word straight through, never stored.
    assign w_bypass = w_empty & fetch_valid & dec_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = fetch_valid & ~w_full & ~flush & ~w_bypass;
    assign w_pop  = ~w_empty & dec_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= fetch_instr;
            r_pc_mem[r_wr_ptr]    <= fetch_pc;
        end
    end

    always_comb begin
        dec_valid = 1'b0;
        dec_instr = NOP_INSTR;
        dec_pc    = '0;
        if (!w_empty) begin
            dec_valid = 1'b1;
            dec_instr = r_instr_mem[r_rd_ptr];
            dec_pc    = r_pc_mem[r_rd_ptr];
        end else if (w_bypass) begin
            dec_valid = 1'b1;
            dec_instr = fetch_instr;
            dec_pc    = fetch_pc;
        end
    end

    assign dec_pc_plus4 = dec_pc + PC_STEP;
    assign fetch_ready  = ~w_full;
    assign count        = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised and directed bench for fetch_buffer, checked every cycle against a queue-based model.
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_instr = '0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    ent_t        mq[$];
    logic [31:0] got[$];

    fetch_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .flush        (flush),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .dec_pc_plus4 (dec_pc_plus4),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of stored entries, updated on the same edges as the DUT.
    always @(posedge clk or negedge rst) begin
        bit do_pop;
        bit do_push;
        bit byp;
        if (!rst) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
            byp = (mq.size() == 0) && fetch_valid && dec_ready;
`endif
            do_pop  = (mq.size() != 0) && dec_ready;
            do_push = fetch_valid && (mq.size() < DEPTH) && !byp;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({fetch_instr, fetch_pc});
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = 1'b0;
        ei = 32'h0000_0013;
        ep = 32'h0;
        if (mq.size() != 0) begin
            ev = 1'b1;
            ei = mq[0].instr;
            ep = mq[0].pc;
        end
`ifdef FETCH_BUFFER_BYPASS_EN
        else if (fetch_valid && dec_ready && !flush) begin
            ev = 1'b1;
            ei = fetch_instr;
            ep = fetch_pc;
        end
`endif
        chk("cyc_dec_valid", 32'(dec_valid), 32'(ev));
        chk("cyc_count", 32'(count), 32'(mq.size()));
        chk("cyc_fetch_ready", 32'(fetch_ready), 32'(mq.size() != DEPTH));
        chk("cyc_dec_instr", dec_instr, ei);
        chk("cyc_dec_pc", dec_pc, ep);
        chk("cyc_dec_pc_plus4", dec_pc_plus4, ep + 32'd4);
    end

    task automatic set_in(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                          input logic dr, input logic fl);
        fetch_valid = fv;
        fetch_instr = ins;
        fetch_pc    = pc;
        dec_ready   = dr;
        flush       = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int next_idx;
        logic fv;
        logic dr;

        // Reset values, while held and after release
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'h0000_0013);
        chk("rst_dec_pc_plus4", dec_pc_plus4, 32'h4);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("idle_dec_valid", 32'(dec_valid), 32'd0);
        chk("idle_dec_instr", dec_instr, 32'h0000_0013);
        chk("idle_dec_pc", dec_pc, 32'h0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'hA0 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("full_dec_pc", dec_pc, 32'h0);
        chk("full_dec_instr", dec_instr, 32'hA0);
        chk("full_dec_pc_plus4", dec_pc_plus4, 32'h4);

        // Full with both sides active: only the pop happens
        set_in(1'b1, 32'hB0, 32'h10, 1'b1, 1'b0);
        #1;
        chk("full_nopass_ready", 32'(fetch_ready), 32'd0);
        tick();
        idle();
        #1;
        chk("popfull_count", 32'(count), 32'd3);
        chk("popfull_dec_pc", dec_pc, 32'h4);
        chk("popfull_fetch_ready", 32'(fetch_ready), 32'd1);

        // Wrap-around: ten sequential PCs, occupancy kept within 1..DEPTH
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
        next_idx = 0;
        got.delete();
        for (int it = 0; it < 200 && got.size() < 10; it++) begin
            fv = (next_idx < 10) && ((mq.size() == 0) || ($urandom_range(0, 3) != 0));
            if (mq.size() >= 2) dr = 1'($urandom_range(0, 1));
            else if (next_idx >= 10 && mq.size() >= 1) dr = 1'b1;
            else dr = 1'b0;
            set_in(fv, 32'hC0 + 32'(next_idx), 32'(next_idx * 4), dr, 1'b0);
            #1;
            if (dec_valid && dec_ready) got.push_back(dec_pc);
            if (fv && mq.size() < DEPTH) next_idx++;
            tick();
        end
        idle();
        chk("wrap_pop_count", 32'(got.size()), 32'd10);
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            chk("wrap_pc_order", got[k], 32'(k * 4));
        end

        // Flush with a same-cycle push and pop pending
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h100 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'hBAD, 32'h200, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_dec_valid", 32'(dec_valid), 32'd0);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd1);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk("flush2_count", 32'(count), 32'd0);
        set_in(1'b1, 32'hD0, 32'h40, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk("postflush_dec_pc", dec_pc, 32'h40);
        chk("postflush_dec_instr", dec_instr, 32'hD0);

        // Empty buffer, fetch and decode both active
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 32'hE0, 32'h80, 1'b1, 1'b0);
        #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("byp_dec_valid", 32'(dec_valid), 32'd1);
        chk("byp_dec_pc", dec_pc, 32'h80);
        chk("byp_dec_pc_plus4", dec_pc_plus4, 32'h84);
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_dec_valid", 32'(dec_valid), 32'd0);
`endif
        tick();
        idle();
        #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("byp_next_count", 32'(count), 32'd0);
        chk("byp_next_dec_valid", 32'(dec_valid), 32'd0);
`else
        chk("nobyp_next_dec_pc", dec_pc, 32'h80);
        chk("nobyp_next_dec_valid", 32'(dec_valid), 32'd1);
        chk("nobyp_next_count", 32'(count), 32'd1);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            tick();
        end

        // Asynchronous reset mid-cycle with two entries stored
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'hF0 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("arst_pre_count", 32'(count), 32'd2);
        #1 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_dec_valid", 32'(dec_valid), 32'd0);
        chk("arst_dec_instr", dec_instr, 32'h0000_0013);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("arst_after_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Decoupling instruction queue between the instruction-memory fetch path and the decode pipeline register of the pipelined RV32 core.
- Accepts {instruction, PC} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Lets fetch run ahead while decode stalls. Emptied in one cycle on a control-flow redirect (branch or jump resolved in execute).

Parameters:
- ADDRESS_WIDTH, 32, width of PC values.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, number of entries. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset: 0 = reset asserted.
- fetch_valid  in  1  fetch presents a valid instruction this cycle.
- fetch_ready  out  1  buffer can accept an entry this cycle.
- fetch_instr  in  DATA_WIDTH  fetched instruction word.
- fetch_pc  in  ADDRESS_WIDTH  PC of fetch_instr.
- flush  in  1  redirect: discard all stored entries.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode consumes the head this cycle.
- dec_instr  out  DATA_WIDTH  head instruction.
- dec_pc  out  ADDRESS_WIDTH  head PC.
- dec_pc_plus4  out  ADDRESS_WIDTH  head PC + 4.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage is a circular buffer of DEPTH entries: instruction and PC.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits; count register.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during reset: dec_valid=0, fetch_ready=1, dec_instr=32'h00000013 (NOP), dec_pc=0, dec_pc_plus4=4, count=0.
  - Entry contents are not reset.
- Signal definitions:
  - fetch_ready = (count != DEPTH). Combinational from count only; independent of dec_ready and flush.
  - dec_valid = (count != 0).
  - dec_instr and dec_pc come from entry[rd_ptr] when dec_valid=1.
  - When empty, dec_instr=NOP, dec_pc=0 and dec_pc_plus4=4. This is a defined value, not don't-care.
  - dec_pc_plus4 = dec_pc + 4, truncated modulo 2^ADDRESS_WIDTH.
- Handshake:
  - push = fetch_valid & fetch_ready & ~flush.
  - pop = dec_valid & dec_ready & ~flush.
- Push: on the clock edge, write entry[wr_ptr]; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Latency: an entry pushed at edge N is visible on dec_* after edge N (1 cycle), assuming it reaches the head.
- Ordering: strictly FIFO; the PC travels with its instruction.
- Full buffer: fetch_ready=0 even if dec_ready=1 in the same cycle (no push-through when full). The freed slot is offered the next cycle.
- Empty buffer: dec_valid=0. dec_ready is ignored and the pointers do not move.
- Flush (synchronous, highest priority): at the edge with flush=1, wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle push or pop is discarded.
  - dec_valid=0 and fetch_ready=1 the following cycle.
  - Flush on an already-empty buffer is harmless.
  - Back-to-back flushes keep the buffer empty.
- Reset mid-operation: asynchronous reset clears the state immediately regardless of clk, and all in-flight entries are lost.
  - Release of reset is synchronised by the integrator.
- No error outputs. Pushing while full cannot occur because push is gated by fetch_ready.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when count==0, fetch_valid=1, dec_ready=1 and flush=0, the fetch inputs drive dec_* combinationally in the same cycle.
  - dec_valid=1 and dec_pc_plus4 = fetch_pc + 4.
  - The entry is consumed without being written, so pointers and count are unchanged.
  - When empty with dec_ready=0, a push is stored normally.
  - This gives 0-cycle latency through an empty buffer.
- Not defined: the bypass logic is absent. Latency is always 1 cycle, and dec_valid is never asserted while count==0.

Test Plan:
- Reset, then release with no stimulus -> dec_valid=0, fetch_ready=1, count=0, dec_instr=0x00000013, dec_pc_plus4=4. Assert rst=0 mid-cycle with 2 entries stored -> count=0 immediately, without waiting for a clock edge.
- Push PCs 0x00,0x04,0x08,0x0C with instrs 0xA0..0xA3, dec_ready=0 -> count=4 and fetch_ready=0 after the 4th edge; dec_pc=0x00, dec_instr=0xA0, dec_pc_plus4=0x04.
- Full buffer with fetch_valid=1 and dec_ready=1 for one cycle -> only a pop occurs: count=3, dec_pc=0x04. The next cycle fetch_ready=1.
- Wrap-around: push and pop 10 sequential PCs 0x00..0x24 while holding the occupancy between 1 and 4 -> dec_pc sequence exactly 0x00,0x04,...,0x24 with no loss or duplication.
- Three stored entries; at one edge flush=1 with fetch_valid=1 and dec_ready=1 -> count=0 and dec_valid=0 next cycle. The entry pushed after that (PC 0x40) is the first one seen on dec_pc.
- With FETCH_BUFFER_BYPASS_EN: empty buffer, fetch_valid=1, dec_ready=1, fetch_pc=0x80 -> same cycle dec_valid=1, dec_pc=0x80, dec_pc_plus4=0x84; count stays 0. Without the macro, the same stimulus gives dec_valid=0 in that cycle and dec_pc=0x80 the next cycle.
